// File: rtl/sqrt_reconstruct.sv
// Rebuilds the radicand root*root + rem from a square-root result. A W-cycle
// shift-add multiplier does the work, and pairs that are not canonical are flagged.
module sqrt_reconstruct #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     root,
    input  logic [W:0]       rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   value,
    output logic             rem_err,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high. valid does not wait for ready, and a result is held
    // unchanged until it is taken.

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    assign value     = acc;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rem_err   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= (2*W)'(root);
                        mplier   <= root;
                        // rem is added first, so the multiply only has to accumulate root*root.
                        acc      <= (2*W)'(rem);
                        cnt      <= '0;
                        rem_err  <= (rem > {root, 1'b0});
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Fixed W-cycle latency. The loop keeps running after the multiplier empties.
                    if (cnt == CW'(W - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Scoreboard bench for sqrt_reconstruct with W=4. It runs directed vectors with
// hand-computed results, a backpressure case, a reset abort and a full round trip.
module tb_sqrt_reconstruct;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   root;
    logic [W:0]     rem;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] value;
    logic           rem_err;
    logic [1:0]     state_dbg;

    // {root[17:14], rem[13:9], rem_err[8], value[7:0]}
    logic [17:0] exp_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  rand_mode = 0;
    bit  ready_force = 1;
    bit  exhaustive = 0;
    int  hits[256];

    sqrt_reconstruct #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .root      (root),
        .rem       (rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value),
        .rem_err   (rem_err),
        .state_dbg (state_dbg)
    );

    // Clock and a global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // out_ready is driven by this one process: either forced or random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        for (int k = 0; k < 16; k++) begin
            if (k * k <= v) r = k;
        end
        return r;
    endfunction

    // Monitor: takes each result the DUT hands over and checks it against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                logic [17:0] e;
                int r;
                e = exp_q.pop_front();
                r = int'(e[17:14]);
                check("value", int'(value), int'(e[7:0]));
                check("rem_err", int'(rem_err), int'(e[8]));
                if (!e[8]) begin
                    check("isqrt_round_trip", isqrt(int'(value)), r);
                    check("rem_round_trip", int'(value) - r * r, int'(e[13:9]));
                end
                if (exhaustive) hits[value]++;
            end
        end
    end

    task automatic send(input int r, input int m, input int exp_val, input int exp_err,
                        input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            root     = W'(r);
            rem      = (W+1)'(m);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            root     = W'($urandom_range(0, 15));
            rem      = (W+1)'($urandom_range(0, 31));
            if (push) exp_q.push_back({4'(r), 5'(m), 1'(exp_err), 8'(exp_val)});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 256; i++) hits[i] = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        root     = '0;
        rem      = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_value", int'(value), 0);
        check("reset_rem_err", int'(rem_err), 0);
        rst_n = 1'b1;

        // Canonical maximum, checking the latency edge by edge.
        send(15, 30, 255, 0, 1);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #2;
            if (k < W) check("early_out_valid", int'(out_valid), 0);
            else       check("latency_out_valid", int'(out_valid), 1);
        end
        drain();

        send(0, 0, 0, 0, 1);
        send(0, 1, 1, 1, 1);
        send(15, 31, 0, 1, 1);
        send(3, 7, 16, 1, 1);
        drain();

        // Backpressure: hold the result for 6 cycles, then release it.
        ready_force = 0;
        @(posedge clk);
        #2;
        send(9, 4, 85, 0, 1);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_out_valid", int'(out_valid), 1);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_value_stable", int'(value), 85);
            check("bp_out_valid_held", int'(out_valid), 1);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        ready_force = 1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);
        drain();

        // Reset during the second MUL cycle aborts the operation.
        send(12, 5, 149, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_value", int'(value), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_state", int'(state_dbg), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(12, 5, 149, 0, 1);
        drain();

        // Every canonical pair, back to back, with random backpressure.
        exhaustive = 1;
        rand_mode  = 1;
        for (int r = 0; r < 16; r++) begin
            for (int m = 0; m <= 2 * r; m++) begin
                send(r, m, r * r + m, 0, 1);
            end
        end
        drain();
        rand_mode  = 0;
        exhaustive = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (hits[i] != 1) bad++;
        end
        check("round_trip_coverage_bad", bad, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
